// File: rtl/game_pkg.sv
// Shared game types: phase codes and cell/position widths used by the
// placement front-end, the game board and the display.
package game_pkg;

  typedef enum logic [1:0] {
    PH_IDLE   = 2'b11,
    PH_HOST   = 2'b01,
    PH_GUEST  = 2'b10,
    PH_BATTLE = 2'b00
  } phase_t;

  localparam int CELL_W = 3;
  localparam int POS_W  = 6;

endpackage

// File: rtl/pix2cell.sv
// Fixed-latency pixel-to-cell divider: GRID_N cycles of parallel repeated
// subtraction on the board-relative offsets, counters saturating at GRID_N.
module pix2cell
  import game_pkg::*;
#(
  parameter int BOARD_X = 100,
  parameter int BOARD_Y = 100,
  parameter int CELL_PX = 48,
  parameter int GRID_N  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] x,
  input  logic [11:0] y,
  output logic [3:0]  row,
  output logic [3:0]  col,
  output logic        valid,
  output logic        done
);

  localparam logic signed [12:0] CELL_S  = 13'(CELL_PX);
  localparam logic signed [12:0] ORG_X_S = 13'(BOARD_X);
  localparam logic signed [12:0] ORG_Y_S = 13'(BOARD_Y);
  localparam logic [3:0]         GRID_S  = 4'(GRID_N);

  logic signed [12:0] xo_r;
  logic signed [12:0] yo_r;
  logic [3:0]         row_r;
  logic [3:0]         col_r;
  logic [3:0]         cnt_r;
  logic               run_r;

  // Load offsets on start, then one subtraction step per axis per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      xo_r  <= 13'sd0;
      yo_r  <= 13'sd0;
      row_r <= 4'd0;
      col_r <= 4'd0;
      cnt_r <= 4'd0;
      run_r <= 1'b0;
    end else if (start) begin
      xo_r  <= $signed({1'b0, x}) - ORG_X_S;
      yo_r  <= $signed({1'b0, y}) - ORG_Y_S;
      row_r <= 4'd0;
      col_r <= 4'd0;
      cnt_r <= 4'd0;
      run_r <= 1'b1;
    end else if (run_r) begin
      // A negative offset never passes the compare, so it stays flagged by its sign bit.
      if (xo_r >= CELL_S && col_r < GRID_S) begin
        xo_r  <= xo_r - CELL_S;
        col_r <= col_r + 4'd1;
      end
      if (yo_r >= CELL_S && row_r < GRID_S) begin
        yo_r  <= yo_r - CELL_S;
        row_r <= row_r + 4'd1;
      end
      cnt_r <= cnt_r + 4'd1;
      if (cnt_r == GRID_S - 4'd1) begin
        run_r <= 1'b0;
      end
    end
  end

  assign row   = row_r;
  assign col   = col_r;
  assign done  = run_r && (cnt_r == GRID_S - 4'd1);
  assign valid = !xo_r[12] && !yo_r[12] && (row_r < GRID_S) && (col_r < GRID_S);

endmodule

// File: rtl/placement_ctrl.sv
// Mouse front-end of the ship-board matrix: click edge detect, cell conversion,
// occupancy check and the IDLE/HOST/GUEST/BATTLE phase sequencer.
module placement_ctrl
  import game_pkg::*;
#(
  parameter int BOARD_X    = 100,
  parameter int BOARD_Y    = 100,
  parameter int CELL_PX    = 48,
  parameter int GRID_N     = 8,
  parameter int SHIP_COUNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [11:0]      xpos,
  input  logic [11:0]      ypos,
  input  logic             mouse_left,
  output logic [1:0]       start,
  output logic             place,
  output logic [POS_W-1:0] mouse_pos,
  output logic [6:0]       ships_left,
  output logic             busy
);

  localparam int         CELLS  = GRID_N * GRID_N;
  localparam logic [6:0] SHIPS7 = 7'(SHIP_COUNT);

  typedef enum logic [1:0] {ST_WAIT, ST_CONV, ST_CHECK, ST_EMIT} conv_state_t;

  conv_state_t       state_r;
  phase_t            phase_r;
  logic              btn_prev_r;
  logic [CELLS-1:0]  occ_r;
  logic              place_r;
  logic              busy_r;
  logic [POS_W-1:0]  pos_r;
  logic [6:0]        ships_r;

  logic              click_s;
  logic              conv_done_s;
  logic              conv_valid_s;
  logic [3:0]        conv_row_s;
  logic [3:0]        conv_col_s;
  logic [POS_W-1:0]  cell_pos_s;
  logic [POS_W-1:0]  bit_idx_s;
  logic              accept_s;

  assign click_s = mouse_left && !btn_prev_r && (state_r == ST_WAIT);

  pix2cell #(
    .BOARD_X (BOARD_X),
    .BOARD_Y (BOARD_Y),
    .CELL_PX (CELL_PX),
    .GRID_N  (GRID_N)
  ) u_pix2cell (
    .clk   (clk),
    .rst   (rst),
    .start (click_s),
    .x     (xpos),
    .y     (ypos),
    .row   (conv_row_s),
    .col   (conv_col_s),
    .valid (conv_valid_s),
    .done  (conv_done_s)
  );

  // Cell address and accept decision, evaluated while in CHECK.
  always_comb begin
    cell_pos_s = {conv_row_s[CELL_W-1:0], conv_col_s[CELL_W-1:0]};
    bit_idx_s  = POS_W'(conv_row_s[CELL_W-1:0]) * POS_W'(GRID_N) + POS_W'(conv_col_s[CELL_W-1:0]);
    if (phase_r != PH_IDLE && conv_valid_s) begin
      accept_s = !occ_r[bit_idx_s];
    end else begin
      accept_s = 1'b0;
    end
  end

  // Conversion sequencer, occupancy map and phase progression.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_WAIT;
      phase_r    <= PH_IDLE;
      btn_prev_r <= 1'b0;
      occ_r      <= '0;
      place_r    <= 1'b0;
      busy_r     <= 1'b0;
      pos_r      <= '0;
      ships_r    <= 7'd0;
    end else begin
      btn_prev_r <= mouse_left;
      place_r    <= 1'b0;
      case (state_r)
        ST_WAIT: begin
          if (click_s) begin
            state_r <= ST_CONV;
            busy_r  <= 1'b1;
          end
        end
        ST_CONV: begin
          if (conv_done_s) begin
            state_r <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          state_r <= ST_EMIT;
          if (accept_s) begin
            place_r           <= 1'b1;
            pos_r             <= cell_pos_s;
            occ_r[bit_idx_s]  <= 1'b1;
          end
        end
        ST_EMIT: begin
          state_r <= ST_WAIT;
          busy_r  <= 1'b0;
          // Phase moves only after the strobe so start is stable alongside place.
          case (phase_r)
            PH_IDLE: begin
              phase_r <= PH_HOST;
              ships_r <= SHIPS7;
            end
            PH_HOST: begin
              if (place_r) begin
                if (ships_r == 7'd1) begin
                  phase_r <= PH_GUEST;
                  ships_r <= SHIPS7;
                  occ_r   <= '0;
                end else begin
                  ships_r <= ships_r - 7'd1;
                end
              end
            end
            PH_GUEST: begin
              if (place_r) begin
                if (ships_r == 7'd1) begin
                  phase_r <= PH_BATTLE;
                  ships_r <= 7'd0;
                  occ_r   <= '0;
                end else begin
                  ships_r <= ships_r - 7'd1;
                end
              end
            end
            PH_BATTLE: begin
              phase_r <= PH_BATTLE;
            end
            default: begin
              phase_r <= PH_IDLE;
            end
          endcase
        end
        default: begin
          state_r <= ST_WAIT;
        end
      endcase
    end
  end

  assign start      = phase_r;
  assign place      = place_r;
  assign mouse_pos  = pos_r;
  assign ships_left = ships_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_placement_ctrl.sv
// Directed testbench for placement_ctrl: phase sequencing, click timing,
// off-board/repeat rejection, busy drop and reset during conversion.
module tb_placement_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] xpos = 12'd0;
  logic [11:0] ypos = 12'd0;
  logic        mouse_left = 1'b0;
  logic [1:0]  start;
  logic        place;
  logic [5:0]  mouse_pos;
  logic [6:0]  ships_left;
  logic        busy;

  int tests_run = 0;
  int tests_failed = 0;

  placement_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .xpos       (xpos),
    .ypos       (ypos),
    .mouse_left (mouse_left),
    .start      (start),
    .place      (place),
    .mouse_pos  (mouse_pos),
    .ships_left (ships_left),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Stimulus only: one-cycle click, then observe for 'cycles' edges.
  // k counts edges from the sampling edge; k=10 is the expected place cycle.
  task automatic do_click(input logic [11:0] x, input logic [11:0] y, input int cycles,
                          output int place_k, output int places, output int busy_n,
                          output logic [1:0] start10);
    @(negedge clk);
    xpos = x; ypos = y; mouse_left = 1'b1;
    place_k = -1; places = 0; busy_n = 0; start10 = 2'bxx;
    for (int k = 1; k <= cycles; k++) begin
      @(posedge clk); #1;
      if (place === 1'b1) begin places++; place_k = k; end
      if (busy === 1'b1) busy_n++;
      if (k == 10) start10 = start;
      if (k == 1) mouse_left = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; mouse_left = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++; if (start !== 2'b11) begin tests_failed++; $display("FAIL reset_start got %b exp 11", start); end
    tests_run++; if (place !== 1'b0) begin tests_failed++; $display("FAIL reset_place got %b exp 0", place); end
    tests_run++; if (mouse_pos !== 6'h00) begin tests_failed++; $display("FAIL reset_pos got %h exp 00", mouse_pos); end
    tests_run++; if (ships_left !== 7'd0) begin tests_failed++; $display("FAIL reset_ships got %0d exp 0", ships_left); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b exp 0", busy); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_idle_click();
    int pk, pn, bn; logic [1:0] s10;
    do_click(12'd150, 12'd150, 12, pk, pn, bn, s10);
    tests_run++; if (pn != 0) begin tests_failed++; $display("FAIL idle_no_place got %0d strobes exp 0", pn); end
    tests_run++; if (bn != 10) begin tests_failed++; $display("FAIL idle_busy_len got %0d exp 10", bn); end
    tests_run++; if (s10 !== 2'b11) begin tests_failed++; $display("FAIL idle_start_at_emit got %b exp 11", s10); end
    tests_run++; if (start !== 2'b01) begin tests_failed++; $display("FAIL idle_to_host got %b exp 01", start); end
    tests_run++; if (ships_left !== 7'd4) begin tests_failed++; $display("FAIL idle_ships got %0d exp 4", ships_left); end
  endtask

  task automatic test_host_place();
    int pk, pn, bn; logic [1:0] s10;
    do_click(12'd201, 12'd254, 12, pk, pn, bn, s10);
    tests_run++; if (pn != 1 || pk != 10) begin tests_failed++; $display("FAIL host_place_timing got %0d strobes at k=%0d exp 1 at k=10", pn, pk); end
    tests_run++; if (mouse_pos !== 6'h1A) begin tests_failed++; $display("FAIL host_pos got %h exp 1a", mouse_pos); end
    tests_run++; if (ships_left !== 7'd3) begin tests_failed++; $display("FAIL host_ships got %0d exp 3", ships_left); end
    tests_run++; if (s10 !== 2'b01) begin tests_failed++; $display("FAIL host_start_stable got %b exp 01", s10); end
  endtask

  task automatic test_reject();
    int pk, pn, bn; logic [1:0] s10;
    logic [11:0] xs [3]; logic [11:0] ys [3];
    xs[0] = 12'd201; ys[0] = 12'd254;
    xs[1] = 12'd99;  ys[1] = 12'd300;
    xs[2] = 12'd484; ys[2] = 12'd120;
    for (int i = 0; i < 3; i++) begin
      do_click(xs[i], ys[i], 12, pk, pn, bn, s10);
      tests_run++; if (pn != 0) begin tests_failed++; $display("FAIL reject_%0d got %0d strobes exp 0", i, pn); end
      tests_run++; if (bn != 10) begin tests_failed++; $display("FAIL reject_busy_%0d got %0d exp 10", i, bn); end
    end
    tests_run++; if (ships_left !== 7'd3) begin tests_failed++; $display("FAIL reject_ships got %0d exp 3", ships_left); end
    tests_run++; if (mouse_pos !== 6'h1A) begin tests_failed++; $display("FAIL reject_pos_held got %h exp 1a", mouse_pos); end
  endtask

  // Remaining host ships on board edges: (483,100)->07, (100,147)->00, (148,483)->39.
  task automatic test_host_fill();
    int pk, pn, bn; logic [1:0] s10;
    logic [11:0] xs [3]; logic [11:0] ys [3]; logic [5:0] ep [3];
    xs[0] = 12'd483; ys[0] = 12'd100; ep[0] = 6'h07;
    xs[1] = 12'd100; ys[1] = 12'd147; ep[1] = 6'h00;
    xs[2] = 12'd148; ys[2] = 12'd483; ep[2] = 6'h39;
    for (int i = 0; i < 3; i++) begin
      do_click(xs[i], ys[i], 12, pk, pn, bn, s10);
      tests_run++; if (pn != 1 || mouse_pos !== ep[i]) begin tests_failed++; $display("FAIL host_fill_%0d got %0d strobes pos %h exp 1 pos %h", i, pn, mouse_pos, ep[i]); end
    end
    tests_run++; if (start !== 2'b10) begin tests_failed++; $display("FAIL host_to_guest got %b exp 10", start); end
    tests_run++; if (ships_left !== 7'd4) begin tests_failed++; $display("FAIL guest_ships got %0d exp 4", ships_left); end
  endtask

  task automatic test_guest();
    int pk, pn, bn; logic [1:0] s10;
    logic [11:0] xs [4]; logic [11:0] ys [4]; logic [5:0] ep [4];
    xs[0] = 12'd201; ys[0] = 12'd254; ep[0] = 6'h1A;
    xs[1] = 12'd250; ys[1] = 12'd250; ep[1] = 6'h1B;
    xs[2] = 12'd300; ys[2] = 12'd300; ep[2] = 6'h24;
    xs[3] = 12'd400; ys[3] = 12'd400; ep[3] = 6'h36;
    for (int i = 0; i < 4; i++) begin
      do_click(xs[i], ys[i], 12, pk, pn, bn, s10);
      tests_run++; if (pn != 1 || pk != 10 || mouse_pos !== ep[i]) begin tests_failed++; $display("FAIL guest_%0d got %0d strobes k=%0d pos %h exp 1 k=10 pos %h", i, pn, pk, mouse_pos, ep[i]); end
      tests_run++; if (s10 !== 2'b10) begin tests_failed++; $display("FAIL guest_start_%0d got %b exp 10", i, s10); end
    end
    tests_run++; if (start !== 2'b00) begin tests_failed++; $display("FAIL guest_to_battle got %b exp 00", start); end
    tests_run++; if (ships_left !== 7'd0) begin tests_failed++; $display("FAIL battle_ships got %0d exp 0", ships_left); end
  endtask

  task automatic test_battle();
    int pk, pn, bn; logic [1:0] s10;
    do_click(12'd201, 12'd254, 12, pk, pn, bn, s10);
    tests_run++; if (pn != 1 || mouse_pos !== 6'h1A) begin tests_failed++; $display("FAIL battle_shot got %0d strobes pos %h exp 1 pos 1a", pn, mouse_pos); end
    tests_run++; if (s10 !== 2'b00 || start !== 2'b00) begin tests_failed++; $display("FAIL battle_phase got %b/%b exp 00/00", s10, start); end
    do_click(12'd201, 12'd254, 12, pk, pn, bn, s10);
    tests_run++; if (pn != 0) begin tests_failed++; $display("FAIL battle_repeat got %0d strobes exp 0", pn); end
  endtask

  task automatic test_back_to_back();
    int pn, pk;
    @(negedge clk);
    xpos = 12'd110; ypos = 12'd110; mouse_left = 1'b1;
    pn = 0; pk = -1;
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk); #1;
      if (place === 1'b1) begin pn++; pk = k; end
      if (k == 1) mouse_left = 1'b0;
      if (k == 3) begin xpos = 12'd300; ypos = 12'd300; mouse_left = 1'b1; end
      if (k == 4) mouse_left = 1'b0;
    end
    tests_run++; if (pn != 1 || pk != 10) begin tests_failed++; $display("FAIL busy_drop got %0d strobes k=%0d exp 1 k=10", pn, pk); end
    tests_run++; if (mouse_pos !== 6'h00) begin tests_failed++; $display("FAIL busy_drop_pos got %h exp 00", mouse_pos); end
    // The dropped cell (4,4) must still be free.
    begin
      int pk2, pn2, bn2; logic [1:0] s10;
      do_click(12'd300, 12'd300, 12, pk2, pn2, bn2, s10);
      tests_run++; if (pn2 != 1 || mouse_pos !== 6'h24) begin tests_failed++; $display("FAIL dropped_cell_free got %0d strobes pos %h exp 1 pos 24", pn2, mouse_pos); end
    end
    // Button held continuously counts once.
    @(negedge clk);
    xpos = 12'd160; ypos = 12'd110; mouse_left = 1'b1;
    pn = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (place === 1'b1) pn++;
    end
    mouse_left = 1'b0;
    tests_run++; if (pn != 1 || mouse_pos !== 6'h01) begin tests_failed++; $display("FAIL held_button got %0d strobes pos %h exp 1 pos 01", pn, mouse_pos); end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_rst_mid();
    int pn;
    @(negedge clk);
    xpos = 12'd350; ypos = 12'd110; mouse_left = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      if (k == 1) mouse_left = 1'b0;
    end
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_busy_before got %b exp 1", busy); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests_run++; if (start !== 2'b11) begin tests_failed++; $display("FAIL rst_mid_start got %b exp 11", start); end
    tests_run++; if (ships_left !== 7'd0) begin tests_failed++; $display("FAIL rst_mid_ships got %0d exp 0", ships_left); end
    tests_run++; if (mouse_pos !== 6'h00) begin tests_failed++; $display("FAIL rst_mid_pos got %h exp 00", mouse_pos); end
    tests_run++; if (busy !== 1'b0 || place !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_busy_place got %b/%b exp 0/0", busy, place); end
    pn = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (place === 1'b1) pn++;
    end
    tests_run++; if (pn != 0) begin tests_failed++; $display("FAIL rst_mid_no_strobe got %0d exp 0", pn); end
  endtask

  initial begin
    test_reset();
    test_idle_click();
    test_host_place();
    test_reject();
    test_host_fill();
    test_guest();
    test_battle();
    test_back_to_back();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
